// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter.
package arb_pkg;
  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 8;
  localparam int ARB_HCNT_W       = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotate-and-pick: first requester at or after ptr, wrapping modulo N.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter  int N  = ARB_N_DEF,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    j        = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter; define ARB_HOLD_EN to let a holder keep the
// grant for up to MAX_HOLD consecutive cycles.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = ARB_N_DEF,
  parameter  int MAX_HOLD = ARB_MAX_HOLD_DEF,
  localparam int IW       = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_arbiter: N or MAX_HOLD out of range");
  end

  logic [IW-1:0] ptr;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          any;
  logic [IW-1:0] ptr_nxt;
  logic          hold;

  arb_rr_pick #(.N(N)) u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  assign ptr_nxt = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);

`ifdef ARB_HOLD_EN
  localparam logic [ARB_HCNT_W-1:0] HOLD_LAST = ARB_HCNT_W'(MAX_HOLD - 1);

  logic [ARB_HCNT_W-1:0] hcnt;

  // Holder keeps the grant only while still requesting and under its budget.
  assign hold = gnt_valid && req[gnt_idx] && (hcnt < HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      hcnt <= '0;
    else if (hold) hcnt <= hcnt + ARB_HCNT_W'(1);
    else           hcnt <= '0;
  end
`else
  assign hold = 1'b0;
`endif

  // ptr moves only on a fresh grant; an idle cycle leaves it where it was.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
    end else if (!hold) begin
      gnt       <= pick;
      gnt_valid <= any;
      gnt_idx   <= pick_idx;
      if (any) ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, MAX_HOLD=3); follows ARB_HOLD_EN if defined.
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(input string tag, input logic [3:0] eg, input logic [1:0] ei);
    chk({tag, ".gnt"},   32'(gnt),       32'(eg));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(eg != 4'b0));
    chk({tag, ".idx"},   32'(gnt_idx),   32'(ei));
  endtask

  task automatic run(input string tag, input logic [3:0] r, input logic [3:0] eg,
                     input logic [1:0] ei);
    req = r;
    step();
    chk_g(tag, eg, ei);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    // reset held with everyone requesting, then released
    #1 rst = 1'b0;
    req = 4'hf;
    #1 chk_g("rst_async", 4'b0000, 2'd0);
    step();
    chk_g("rst_edge", 4'b0000, 2'd0);
    step();
    rst = 1'b1;
    run("rr0", 4'hf, 4'b0001, 2'd0);
`ifndef ARB_HOLD_EN
    run("rr1", 4'hf, 4'b0010, 2'd1);
    run("rr2", 4'hf, 4'b0100, 2'd2);
    run("rr3", 4'hf, 4'b1000, 2'd3);
    run("rr4", 4'hf, 4'b0001, 2'd0);
    run("rr5", 4'hf, 4'b0010, 2'd1);
`else
    run("rr1", 4'hf, 4'b0001, 2'd0);
    run("rr2", 4'hf, 4'b0001, 2'd0);
    run("rr3", 4'hf, 4'b0010, 2'd1);
`endif

    // idle cycles keep ptr; grant at 3 wraps ptr to 0
    do_reset();
    run("w0",    4'b1000, 4'b1000, 2'd3);
    run("idle0", 4'b0000, 4'b0000, 2'd0);
    run("idle1", 4'b0000, 4'b0000, 2'd0);
    run("wrap",  4'b1001, 4'b0001, 2'd0);
`ifndef ARB_HOLD_EN
    run("wrap2", 4'b1001, 4'b1000, 2'd3);
`else
    run("wrap2", 4'b1001, 4'b0001, 2'd0);
`endif

    // two steady requesters
    do_reset();
`ifndef ARB_HOLD_EN
    run("alt0", 4'b0101, 4'b0001, 2'd0);
    run("alt1", 4'b0101, 4'b0100, 2'd2);
    run("alt2", 4'b0101, 4'b0001, 2'd0);
    run("alt3", 4'b0101, 4'b0100, 2'd2);
`else
    run("hold0", 4'b0101, 4'b0001, 2'd0);
    run("hold1", 4'b0101, 4'b0001, 2'd0);
    run("hold2", 4'b0101, 4'b0001, 2'd0);
    run("hold3", 4'b0101, 4'b0100, 2'd2);
    run("hold4", 4'b0101, 4'b0100, 2'd2);
    run("hold5", 4'b0101, 4'b0100, 2'd2);
    run("hold6", 4'b0101, 4'b0001, 2'd0);
`endif

    // holder drops: no gap before the other requester
    do_reset();
    run("early0", 4'b0101, 4'b0001, 2'd0);
    run("early1", 4'b0100, 4'b0100, 2'd2);

    // sole persistent requester keeps winning
    do_reset();
    for (int i = 0; i < 5; i++) run($sformatf("sole%0d", i), 4'b0010, 4'b0010, 2'd1);

    // request pulse entirely between edges is not seen
    do_reset();
    req = 4'b0001;
    #2 req = 4'b0000;
    step();
    chk_g("glitch", 4'b0000, 2'd0);

    // reset mid-grant drops outputs at once and restores ptr to 0
    run("mg0", 4'b0100, 4'b0100, 2'd2);
    rst = 1'b0;
    #1 chk_g("mg_async", 4'b0000, 2'd0);
    step();
    chk_g("mg_held", 4'b0000, 2'd0);
    rst = 1'b1;
    run("mg_ptr0", 4'b1010, 4'b0010, 2'd1);
    run("mg_regnt", 4'b0100, 4'b0100, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
